// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives newPC, issues one outstanding word fetch
// at a time and buffers responses in an output + skid stage toward decode.
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  newPC,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pending_pc;
    logic                skid_valid;
    logic [INSTR_W-1:0]  skid_instr;
    logic [ADDR_W-1:0]   skid_pc;
    logic                accept;
    logic                load;
    logic                consume;

    // Gating with rst keeps the port quiet while reset is held, even though
    // the state register already reads FETCH with an empty skid.
    assign imem_req  = rst && (state == FETCH) && !skid_valid;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign consume   = instr_valid && instr_ready;

    always_comb begin
        if (redirect_valid)
            newPC = {redirect_target[ADDR_W-1:2], 2'b00};
        else if (accept)
            newPC = pc + ADDR_W'(4);
        else
            newPC = pc;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            FETCH: begin
                if (accept)
                    state_nxt = redirect_valid ? DRAIN : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                    load      = !redirect_valid;
                end else if (redirect_valid) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pending_pc <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && accept && !redirect_valid)
                pending_pc <= pc;
        end
    end

    // Output register plus skid: a response lands in the output register when
    // it is free (or draining this edge), otherwise behind it in the skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (consume || !instr_valid) begin
            if (skid_valid) begin
                instr_valid <= 1'b1;
                instr       <= skid_instr;
                instr_pc    <= skid_pc;
                skid_valid  <= load;
                if (load) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= pending_pc;
                end
            end else if (load) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pending_pc;
            end else begin
                instr_valid <= 1'b0;
            end
        end else if (load) begin
            skid_valid <= 1'b1;
            skid_instr <= imem_rdata;
            skid_pc    <= pending_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for fetch and
// backpressure, then hand-written redirect, wrap-around and reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] newPC;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .newPC           (newPC),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    // PC register of the surrounding pipeline.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'h0;
        else      pc <= newPC;
    end

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_newpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] tgt, input logic g,
                         input logic rvl, input logic [31:0] rd, input logic rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_gnt        = g;
        imem_rvalid     = rvl;
        imem_rdata      = rd;
        instr_ready     = rdy;
        #1;
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Fetch 0x0 then stall decode while 0x4 fills the skid; release decode.
        //            rv tgt gnt rvl rdata          rdy req addr   newpc  val instr          ipc
        vecs[0] = '{0, 0, 0, 0, 32'h0,          0, 1, 32'h0, 32'h0, 0, 32'h0,          32'h0};
        vecs[1] = '{0, 0, 1, 0, 32'h0,          0, 1, 32'h0, 32'h4, 0, 32'h0,          32'h0};
        vecs[2] = '{0, 0, 0, 1, 32'h00000013,   0, 0, 32'h4, 32'h4, 0, 32'h0,          32'h0};
        vecs[3] = '{0, 0, 0, 0, 32'h0,          0, 1, 32'h4, 32'h4, 1, 32'h00000013,   32'h0};
        vecs[4] = '{0, 0, 1, 0, 32'h0,          0, 1, 32'h4, 32'h8, 1, 32'h00000013,   32'h0};
        vecs[5] = '{0, 0, 0, 1, 32'h00100093,   0, 0, 32'h8, 32'h8, 1, 32'h00000013,   32'h0};
        vecs[6] = '{0, 0, 0, 0, 32'h0,          0, 0, 32'h8, 32'h8, 1, 32'h00000013,   32'h0};
        vecs[7] = '{0, 0, 0, 0, 32'h0,          1, 0, 32'h8, 32'h8, 1, 32'h00000013,   32'h0};
        vecs[8] = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h8, 32'h8, 1, 32'h00100093,   32'h4};
        vecs[9] = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h8, 32'h8, 0, 32'h0,          32'h0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_req", {31'b0, imem_req}, 32'h0);
        check("reset_valid", {31'b0, instr_valid}, 32'h0);
        check("reset_instr", instr, 32'h0);
        check("reset_ipc", instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        adv();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rv, vecs[i].tgt, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_newpc", i), newPC, vecs[i].e_newpc);
            check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
                check($sformatf("v%0d_ipc", i), instr_pc, vecs[i].e_ipc);
            end
            adv();
        end

        // Redirect while waiting, response arrives later and is dropped.
        drive(0, 0, 1, 0, 0, 1);
        check("rw_gnt_newpc", newPC, 32'hC);
        adv();
        drive(1, 32'h103, 0, 0, 0, 1);
        check("rw_redir_newpc", newPC, 32'h100);
        check("rw_redir_req", {31'b0, imem_req}, 32'h0);
        adv();
        drive(0, 0, 0, 1, 32'hDEADBEEF, 1);
        check("rw_drain_req", {31'b0, imem_req}, 32'h0);
        adv();
        drive(0, 0, 1, 0, 0, 1);
        check("rw_after_valid", {31'b0, instr_valid}, 32'h0);
        check("rw_after_req", {31'b0, imem_req}, 32'h1);
        check("rw_after_addr", imem_addr, 32'h100);
        adv();
        // Redirect in the same cycle as rvalid while waiting.
        drive(1, 32'h200, 0, 1, 32'hCAFEF00D, 1);
        check("rwr_newpc", newPC, 32'h200);
        adv();
        drive(0, 0, 0, 0, 0, 1);
        check("rwr_valid", {31'b0, instr_valid}, 32'h0);
        check("rwr_req", {31'b0, imem_req}, 32'h1);
        check("rwr_addr", imem_addr, 32'h200);
        adv();

        // Redirect and grant in the same cycle.
        drive(1, 32'h300, 1, 0, 0, 1);
        check("rg_newpc", newPC, 32'h300);
        adv();
        drive(0, 0, 0, 0, 0, 1);
        check("rg_drain_req", {31'b0, imem_req}, 32'h0);
        adv();
        drive(0, 0, 0, 1, 32'h0000BEEF, 1);
        adv();
        drive(0, 0, 0, 0, 0, 1);
        check("rg_valid", {31'b0, instr_valid}, 32'h0);
        check("rg_addr", imem_addr, 32'h300);
        check("rg_req", {31'b0, imem_req}, 32'h1);
        adv();

        // Wrap-around from the top word of the address space.
        drive(1, 32'hFFFFFFFE, 0, 0, 0, 0);
        check("wr_redir_newpc", newPC, 32'hFFFFFFFC);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        check("wr_addr", imem_addr, 32'hFFFFFFFC);
        check("wr_newpc", newPC, 32'h0);
        adv();
        drive(0, 0, 0, 1, 32'h00000073, 0);
        adv();
        // Output held by backpressure, then flushed by a redirect.
        drive(1, 32'h40, 0, 0, 0, 0);
        check("wr_valid", {31'b0, instr_valid}, 32'h1);
        check("wr_instr", instr, 32'h00000073);
        check("wr_ipc", instr_pc, 32'hFFFFFFFC);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        check("fl_valid", {31'b0, instr_valid}, 32'h0);
        check("fl_addr", imem_addr, 32'h40);
        adv();
        drive(0, 0, 0, 1, 32'h00000011, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        check("rs_pre_addr", imem_addr, 32'h44);
        adv();

        // Asynchronous reset while waiting with a valid output.
        drive(0, 0, 0, 0, 0, 0);
        check("rs_pre_valid", {31'b0, instr_valid}, 32'h1);
        check("rs_pre_instr", instr, 32'h00000011);
        rst = 1'b0;
        #1;
        check("rs_async_valid", {31'b0, instr_valid}, 32'h0);
        check("rs_async_req", {31'b0, imem_req}, 32'h0);
        check("rs_async_instr", instr, 32'h0);
        check("rs_async_ipc", instr_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        adv();
        drive(0, 0, 0, 1, 32'h00000055, 0);
        check("rs_fetch_req", {31'b0, imem_req}, 32'h1);
        check("rs_fetch_addr", imem_addr, 32'h0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        check("rs_ignored_valid", {31'b0, instr_valid}, 32'h0);
        check("rs_gnt_newpc", newPC, 32'h4);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that sits between the PC register and instruction memory.
- Each cycle it takes the current `pc`, drives `newPC` back into the PC register, and issues word fetches on a req/gnt/rvalid memory port.
- It buffers fetched instructions in a 2-entry output stage (output register plus skid register) toward decode, using a valid/ready handshake.
- Branch/jump redirects flush buffered and in-flight instructions.

Parameters:
- ADDR_W, 32, width of PC, memory address, redirect target.
- INSTR_W, 32, width of instruction word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC from PC register.
- newPC  out  ADDR_W  next PC, combinational; PC register loads it every clock.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  ADDR_W  redirect destination.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  INSTR_W  read data.
- instr_valid  out  1  instruction available to decode.
- instr  out  INSTR_W  instruction word.
- instr_pc  out  ADDR_W  address instr was fetched from.
- instr_ready  in  1  decode accepts instr this cycle.

Behaviour:
- **States:** FETCH, WAIT, DRAIN. Reset (rst low) forces FETCH asynchronously.
- **Outputs while rst low:** imem_req=0, instr_valid=0, instr=0, instr_pc=0, skid empty.
- **Request rules:**
  - imem_req = (state==FETCH) && !skid_valid.
  - imem_addr = pc.
  - Once asserted, imem_req and imem_addr are held until imem_gnt. At most one request is outstanding.
- **newPC priority** (pc+4 wraps mod 2^ADDR_W):
  1. redirect_valid: newPC = {redirect_target[ADDR_W-1:2], 2'b00}.
  2. imem_req && imem_gnt: newPC = pc+4.
  3. Otherwise: newPC = pc.
- **FETCH transitions:**
  - gnt && !redirect_valid → WAIT; latch the issued address as pending_pc.
  - gnt && redirect_valid → DRAIN.
  - Otherwise stay in FETCH.
  - rvalid in FETCH is ignored.
- **WAIT transitions:**
  - rvalid && !redirect_valid → FETCH; response enters the output stage.
  - rvalid && redirect_valid → FETCH; response discarded.
  - redirect_valid without rvalid → DRAIN.
- **DRAIN transitions:** rvalid → FETCH, data discarded. A redirect while in DRAIN only updates newPC.
- **Output stage:**
  - Response goes to the output register if it is empty or being consumed (instr_valid && instr_ready); otherwise it goes to the skid register.
  - When the output register is consumed and the skid register is full, skid moves to output in the same edge.
  - Ordering is preserved. A skid overflow cannot occur because requests are blocked while skid is full.
- **Flush:** redirect_valid clears instr_valid and skid_valid at the next edge, overriding any same-cycle load. A handshake in the redirect cycle still counts as consumed.
- **Latency and throughput:**
  - gnt at cycle N, rvalid at N+k (k≥1) → instr_valid at N+k+1.
  - Peak throughput is one instruction per 2 cycles.
- All state updates on rising clk. Outputs are registered except newPC, imem_req and imem_addr.

Test Plan:
- **Basic fetch.** Release rst with pc=0, gnt in cycle 1, rvalid+rdata=0x00000013 in cycle 2 → newPC=4 in cycle 1, and in cycle 3 instr_valid=1, instr=0x00000013, instr_pc=0.
- **Backpressure.** instr_ready=0, fetch 0x0 and 0x4 → output=0x0 and skid=0x4, imem_req stays 0. Raise instr_ready → 0x0 then 0x4 delivered on consecutive cycles, then imem_req reasserts with addr 8.
- **Redirect in WAIT.** Redirect to 0x103 while waiting, then rvalid → response discarded, instr_valid stays 0, next imem_addr=0x100.
- **Redirect with gnt.** Redirect and gnt in the same cycle → newPC=target, DRAIN absorbs the next rvalid, no instruction delivered from the old address.
- **Wrap-around.** pc=0xFFFFFFFC granted → newPC=0x00000000, instr_pc=0xFFFFFFFC.
- **Reset in WAIT.** Assert rst mid-WAIT with instr_valid=1 → instr_valid=0 and imem_req=0 immediately (asynchronously). After release, state is FETCH and an rvalid arriving in FETCH is ignored.
